// File: rtl/sync_fifo_param_pkg.sv
// Shared constants for the sync_fifo_param family.
//   Default geometry (data width, depth, pointer width, thresholds) and the output-mode
//   selector values used by the FWFT parameter.
package sync_fifo_param_pkg;

   localparam int unsigned DefDataWidth = 8;
   localparam int unsigned DefDepth     = 16;
   localparam int unsigned DefPtrWidth  = 4;
   localparam int unsigned DefAfLevel   = 12;
   localparam int unsigned DefAeLevel   = 4;

   // Output-mode selector values
   localparam int unsigned FifoStd      = 0;
   localparam int unsigned FifoFwft     = 1;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle of sync_fifo_param.
//   master: drives wr_en, data_in, rd_en, clr_err; observes data and status.
//   slave : the FIFO side; drives data_out, valid, full, empty, almost_full, almost_empty,
//           count, overflow and underflow.
interface sync_fifo_param_if
   import sync_fifo_param_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned PTR_WIDTH  = DefPtrWidth
);

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  rd_en;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [PTR_WIDTH:0]    count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, data_in, rd_en, clr_err,
      input  data_out, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  wr_en, data_in, rd_en, clr_err,
      output data_out, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/sync_fifo_param_ram.sv
// Storage array for sync_fifo_param: DEPTH x DATA_WIDTH, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
module sync_fifo_param_ram
   import sync_fifo_param_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned DEPTH      = DefDepth,
   parameter int unsigned PTR_WIDTH  = DefPtrWidth
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [PTR_WIDTH-1:0]  waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [PTR_WIDTH-1:0]  raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds, sticky
// overflow/underflow and a selectable standard or first-word-fall-through output.
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of sync_fifo_param_if (write/read requests, data, status flags)
// The read pointer always marks the oldest word not yet handed to the consumer, so count,
// full and empty cover the FWFT output register as well as the array.
module sync_fifo_param
   import sync_fifo_param_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned DEPTH      = DefDepth,
   parameter int unsigned PTR_WIDTH  = DefPtrWidth,
   parameter int unsigned AF_LEVEL   = DefAfLevel,
   parameter int unsigned AE_LEVEL   = DefAeLevel,
   parameter int unsigned FWFT       = FifoStd
) (
   input logic              clk,
   input logic              rst_n,
   sync_fifo_param_if.slave bus
);

   localparam bit                 IsFwft = (FWFT == FifoFwft);
   localparam logic [PTR_WIDTH:0] AfLvl  = (PTR_WIDTH + 1)'(AF_LEVEL);
   localparam logic [PTR_WIDTH:0] AeLvl  = (PTR_WIDTH + 1)'(AE_LEVEL);

   logic [PTR_WIDTH:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]    count;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  valid_q, valid_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  full, empty;
   logic                  rd_accept, wr_accept;
   logic [PTR_WIDTH-1:0]  raddr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign count = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                  (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);

   always_comb begin
      rd_accept = IsFwft ? (bus.rd_en && valid_q) : (bus.rd_en && !empty);
      // At full a concurrent pop frees the slot the write lands in
      wr_accept = bus.wr_en && (!full || rd_accept);
      wr_ptr_d  = wr_ptr_q + {{PTR_WIDTH{1'b0}}, wr_accept};
      rd_ptr_d  = rd_ptr_q + {{PTR_WIDTH{1'b0}}, rd_accept};
      raddr     = rd_ptr_q[PTR_WIDTH-1:0];
      valid_d   = rd_accept;
      dout_d    = dout_q;
      if (IsFwft) begin
         // Present the new head; only words stored before this edge qualify, which gives
         // the one-cycle prefetch after a write into an empty FIFO.
         raddr   = rd_ptr_d[PTR_WIDTH-1:0];
         valid_d = (wr_ptr_q != rd_ptr_d);
         if (valid_d) begin
            dout_d = ram_rdata;
         end
      end else if (rd_accept) begin
         dout_d = ram_rdata;
      end
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (bus.clr_err) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end else begin
         if (bus.wr_en && !wr_accept) ovf_d = 1'b1;
         if (bus.rd_en && !rd_accept) udf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   sync_fifo_param_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_ram (
      .clk    (clk),
      .we_i   (wr_accept),
      .waddr_i(wr_ptr_q[PTR_WIDTH-1:0]),
      .wdata_i(bus.data_in),
      .raddr_i(raddr),
      .rdata_o(ram_rdata)
   );

   assign bus.data_out     = dout_q;
   assign bus.valid        = valid_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count >= AfLvl);
   assign bus.almost_empty = (count <= AeLvl);
   assign bus.count        = count;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;

endmodule
